// File: rtl/bpu_update_arbiter_if.sv
// Update channel from EXE, IF lookup request and BHT/BTB write port of the update arbiter.
`default_nettype none

interface bpu_update_arbiter_if #(
  parameter int DEPTH   = 4,
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 23
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               flush;
  logic               upd_valid;
  logic [31:0]        upd_pc;
  logic [1:0]         upd_type;
  logic               upd_taken;
  logic [31:0]        upd_target;
  logic [1:0]         upd_count;
  logic               upd_hit;
  logic               upd_drop;
  logic               if_req;
  logic               if_stall;
  logic               bht_we;
  logic [INDEX_W-1:0] bht_index;
  logic [TAG_W-1:0]   bht_tag;
  logic [31:0]        bht_target;
  logic [1:0]         bht_type;
  logic [1:0]         bht_count;
  logic [CNT_W-1:0]   q_count;

  modport master (
    output flush, upd_valid, upd_pc, upd_type, upd_taken, upd_target, upd_count, upd_hit, if_req,
    input  upd_drop, if_stall, bht_we, bht_index, bht_tag, bht_target, bht_type, bht_count, q_count
  );

  modport slave (
    input  flush, upd_valid, upd_pc, upd_type, upd_taken, upd_target, upd_count, upd_hit, if_req,
    output upd_drop, if_stall, bht_we, bht_index, bht_tag, bht_target, bht_type, bht_count, q_count
  );
endinterface

`default_nettype wire

// File: rtl/bpu_update_arbiter.sv
//------------------------------------------------------------------------------
// bpu_update_arbiter : queues resolved branches and writes them into the BHT/BTB
//                      port, yielding to IF lookups up to a starvation limit.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bpu_update_arbiter #(
  parameter int DEPTH        = 4,
  parameter int INDEX_W      = 7,
  parameter int TAG_W        = 23,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic           clk,
  input  wire logic           resetn,
  bpu_update_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] BIS_NONE = 2'd0;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        target;
    logic [1:0]         btype;
    logic [1:0]         count;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic [SW-1:0]    starve;

  logic   empty;
  logic   full;
  logic   grant;
  logic   filt;
  logic   enq;
  logic   deq;
  entry_t new_entry;
  entry_t head;

  assign empty = (occ == '0);
  assign full  = (occ == CNT_W'(DEPTH));
  assign grant = !empty && (!bus.if_req || starve == SW'(STARVE_LIMIT));
  assign filt  = bus.upd_valid && (bus.upd_type != BIS_NONE) && (bus.upd_hit || bus.upd_taken);
  // A full queue still accepts when the head leaves in the same cycle.
  assign enq   = filt && (!full || grant) && !bus.flush;
  assign deq   = grant;
  assign head  = mem[rd_ptr];

  always_comb begin
    new_entry        = '0;
    new_entry.index  = bus.upd_pc[INDEX_W+1:2];
    new_entry.tag    = bus.upd_pc[31:INDEX_W+2];
    new_entry.target = bus.upd_target;
    new_entry.btype  = bus.upd_type;
    if (!bus.upd_hit) begin
      new_entry.count = 2'b10;
    end else if (bus.upd_taken) begin
      new_entry.count = (bus.upd_count == 2'b11) ? 2'b11 : bus.upd_count + 2'b01;
    end else begin
      new_entry.count = (bus.upd_count == 2'b00) ? 2'b00 : bus.upd_count - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      starve <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ <= occ + CNT_W'(enq) - CNT_W'(deq);
      if (grant || empty) begin
        starve <= '0;
      end else if (bus.if_req) begin
        starve <= starve + SW'(1);
      end
    end
  end

  assign bus.upd_drop   = filt && full && !grant && !bus.flush;
  assign bus.if_stall   = grant && bus.if_req;
  assign bus.bht_we     = grant;
  assign bus.bht_index  = grant ? head.index  : '0;
  assign bus.bht_tag    = grant ? head.tag    : '0;
  assign bus.bht_target = grant ? head.target : '0;
  assign bus.bht_type   = grant ? head.btype  : '0;
  assign bus.bht_count  = grant ? head.count  : '0;
  assign bus.q_count    = occ;

endmodule

`default_nettype wire

// File: tb/tb_bpu_update_arbiter.sv
// Randomized and directed bench for bpu_update_arbiter against a queue-based reference model.
`default_nettype none

module tb_bpu_update_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  bpu_update_arbiter_if #(.DEPTH(DEPTH), .INDEX_W(7), .TAG_W(23)) bus ();

  bpu_update_arbiter #(.DEPTH(DEPTH), .INDEX_W(7), .TAG_W(23), .STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int unsigned index;
    int unsigned tag;
    logic [31:0] target;
    int unsigned btype;
    int unsigned count;
  } ent_t;

  ent_t q[$];
  int   starve;
  int   total = 0;
  int   bad = 0;

  // outputs sampled by the last step, for directed literal checks
  logic s_we, s_stall, s_drop;
  int unsigned s_index, s_tag, s_count, s_qc;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare all outputs with the model, advance the model.
  task automatic step(input logic rn, input logic fl, input logic v, input logic [31:0] pc,
                      input logic [1:0] ty, input logic tk, input logic [1:0] cn,
                      input logic hit, input logic ir);
    bit   g, filt, en, drop;
    ent_t e;
    int   nc;
    @(negedge clk);
    resetn         = rn;
    bus.flush      = fl;
    bus.upd_valid  = v;
    bus.upd_pc     = pc;
    bus.upd_type   = ty;
    bus.upd_taken  = tk;
    bus.upd_target = pc ^ 32'h5a5a_0000;
    bus.upd_count  = cn;
    bus.upd_hit    = hit;
    bus.if_req     = ir;
    #1;
    g    = (q.size() != 0) && (!ir || starve == LIMIT);
    filt = v && (ty != 2'd0) && (hit || tk);
    drop = filt && (q.size() == DEPTH) && !g && !fl;
    en   = filt && ((q.size() < DEPTH) || g) && !fl;

    chk("q_count", bus.q_count, q.size());
    chk("bht_we", bus.bht_we, g);
    chk("if_stall", bus.if_stall, g && ir);
    chk("upd_drop", bus.upd_drop, drop);
    if (g) begin
      chk("bht_index", bus.bht_index, q[0].index);
      chk("bht_tag", bus.bht_tag, q[0].tag);
      chk("bht_target", bus.bht_target, q[0].target);
      chk("bht_type", bus.bht_type, q[0].btype);
      chk("bht_count", bus.bht_count, q[0].count);
    end else begin
      chk("bht_idle", {bus.bht_index, bus.bht_tag, bus.bht_count}, 0);
    end

    s_we = bus.bht_we; s_stall = bus.if_stall; s_drop = bus.upd_drop;
    s_index = bus.bht_index; s_tag = bus.bht_tag; s_count = bus.bht_count; s_qc = bus.q_count;

    if (!rn || fl) begin
      q.delete();
      starve = 0;
    end else begin
      if (g || q.size() == 0) starve = 0;
      else if (ir) starve = starve + 1;
      if (g) void'(q.pop_front());
      if (en) begin
        if (!hit) nc = 2;
        else begin
          nc = tk ? int'(cn) + 1 : int'(cn) - 1;
          if (nc > 3) nc = 3;
          if (nc < 0) nc = 0;
        end
        e.index  = (pc >> 2) % 128;
        e.tag    = pc >> 9;
        e.target = pc ^ 32'h5a5a_0000;
        e.btype  = ty;
        e.count  = nc;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ir);
    step(1, 0, 0, 0, 0, 0, 0, 0, ir);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [1:0] cn,
                     input logic hit, input logic ir);
    step(1, 0, 1, pc, 2'd1, tk, cn, hit, ir);
  endtask

  initial begin
    logic [31:0] rpc;
    starve = 0;
    resetn = 1'b0;
    bus.flush = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_type = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.upd_count = 0; bus.upd_hit = 0; bus.if_req = 0;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("reset_q_count", s_qc, 0);
    chk("reset_we", s_we, 0);

    // basic hit/taken update
    upd(32'h8000_0010, 1, 2'd1, 1, 0);
    chk("t1_no_bypass", s_we, 0);
    idle(0);
    chk("t1_we", s_we, 1);
    chk("t1_index", s_index, 4);
    chk("t1_tag", s_tag, 32'h40_0000);
    chk("t1_count", s_count, 2);
    idle(0);
    chk("t1_q_empty", s_qc, 0);

    // counter saturation and miss allocation
    upd(32'h0000_0100, 1, 2'd3, 1, 0); idle(0); chk("t2_sat_hi", s_count, 3);
    upd(32'h0000_0104, 0, 2'd0, 1, 0); idle(0); chk("t2_sat_lo", s_count, 0);
    upd(32'h0000_0108, 1, 2'd0, 0, 0); idle(0); chk("t2_miss_alloc", s_count, 2);
    upd(32'h0000_010c, 0, 2'd3, 0, 0); chk("t2_filter_drop", s_drop, 0);
    idle(0); chk("t2_filter_q", s_qc, 0);

    // starvation forcing
    upd(32'h0000_0200, 1, 2'd1, 1, 1);
    for (int i = 0; i < LIMIT; i++) begin
      idle(1);
      chk("t3_denied", s_we, 0);
    end
    idle(1);
    chk("t3_forced_we", s_we, 1);
    chk("t3_forced_stall", s_stall, 1);
    idle(1);
    chk("t3_after", s_we, 0);

    // full queue drop, then accept alongside a forced write
    for (int i = 0; i < DEPTH; i++) upd(32'h0000_0300 + 32'(i * 4), 1, 2'd1, 1, 1);
    upd(32'h0000_0400, 1, 2'd1, 1, 1);
    chk("t4_drop", s_drop, 1);
    repeat (LIMIT - DEPTH) idle(1);
    upd(32'h0000_0404, 1, 2'd1, 1, 1);
    chk("t4_forced", s_stall, 1);
    chk("t4_no_drop", s_drop, 0);
    idle(0);
    chk("t4_q_full", s_qc, 4);
    repeat (DEPTH) idle(0);

    // flush with queued entries
    for (int i = 0; i < 3; i++) upd(32'h0000_0500 + 32'(i * 4), 1, 2'd2, 1, 1);
    step(1, 1, 1, 32'h0000_0600, 2'd1, 1, 2'd1, 1, 1);
    idle(0);
    chk("t5_q_flushed", s_qc, 0);
    chk("t5_no_we", s_we, 0);
    idle(0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rpc = $urandom;
      rpc[8:2] = 7'($urandom_range(0, 5));
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 6), rpc, 2'($urandom), 1'($urandom),
           2'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
